// File: rtl/load_align_unit_if.sv
// Bundles the request, memory and result handshakes of load_align_unit.
// The slave view is the alignment unit itself; the master view is its environment
// (execute stage, data memory and result consumer).
interface load_align_unit_if #(
  parameter int XLEN = 32
);
  // Load request from the execute stage
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [4:0]      req_rd;

  // Aligned data-memory read port
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;

  // Aligned, extended result
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned, req_rd,
    output req_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output out_valid, out_data, out_rd, out_err,
    input  out_ready
  );

  modport master (
    output req_valid, req_addr, req_size, req_unsigned, req_rd,
    input  req_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  out_valid, out_data, out_rd, out_err,
    output out_ready
  );
endinterface

// File: rtl/load_align_unit.sv
// Load-data alignment and extension unit. Accepts one load at a time, issues one
// or two aligned memory reads (two when the access crosses a word boundary),
// merges the beats, selects the addressed bytes and sign- or zero-extends them.
module load_align_unit #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  load_align_unit_if.slave bus
);

  localparam int B  = XLEN / 8;       // bytes per memory beat
  localparam int OW = $clog2(B);      // width of the byte offset within a beat

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } state_t;

  state_t          state;
  logic [OW-1:0]   off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            split_q;
  logic [XLEN-1:0] beat0_q;

  // Keep the low bytes selected by size and fill the upper bits with the sign
  // of the kept field (or zeros); a full-width access has no fill bits at all.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] k,
                                             input logic [1:0]      size,
                                             input logic            uns);
    logic [XLEN-1:0] mask;
    logic [6:0]      nbits;
    logic            sign;
    nbits = 7'd8 << size;
    mask  = ~({XLEN{1'b1}} << nbits);
    case (size)
      2'd0:    sign = k[7];
      2'd1:    sign = k[15];
      2'd2:    sign = k[31];
      default: sign = k[XLEN-1];
    endcase
    sign = sign & ~uns;
    return (k & mask) | ({XLEN{sign}} & ~mask);
  endfunction

  // Classification of the request currently offered on the request port
  logic [4:0] req_end;
  logic       req_split;
  logic       req_illegal;
  logic       req_reject;

  assign req_end     = 5'(bus.req_addr[OW-1:0]) + (5'd1 << bus.req_size);
  assign req_split   = req_end > 5'(B);
  assign req_illegal = (XLEN == 32) && (bus.req_size == 2'd3);
  assign req_reject  = req_illegal || (req_split && !ALLOW_MISALIGNED);

  // Final-beat merge: {beat1, beat0} for split loads, {0, beat} otherwise
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   result;

  assign merged = (state == WAIT1) ? {bus.mem_rsp_data, beat0_q}
                                   : {{XLEN{1'b0}}, bus.mem_rsp_data};
  assign result = extend(XLEN'(merged >> {off_q, 3'b000}), size_q, uns_q);

  // Load sequencing FSM; every interface output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      off_q             <= '0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      split_q           <= 1'b0;
      beat0_q           <= '0;
      bus.req_ready     <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_data      <= '0;
      bus.out_rd        <= '0;
      bus.out_err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every branch reads pre-edge register values.
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            off_q         <= bus.req_addr[OW-1:0];
            size_q        <= bus.req_size;
            uns_q         <= bus.req_unsigned;
            split_q       <= req_split;
            bus.out_rd    <= bus.req_rd;
            if (req_reject) begin
              state         <= RESP;
              bus.out_valid <= 1'b1;
              bus.out_err   <= 1'b1;
              bus.out_data  <= '0;
            end else begin
              state             <= REQ0;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= {bus.req_addr[XLEN-1:OW], {OW{1'b0}}};
            end
          end
        end
        REQ0: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT0;
          end
        end
        WAIT0: begin
          if (bus.mem_rsp_valid) begin
            if (split_q) begin
              beat0_q           <= bus.mem_rsp_data;
              state             <= REQ1;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= bus.mem_req_addr + XLEN'(B);
            end else begin
              state         <= RESP;
              bus.out_valid <= 1'b1;
              bus.out_err   <= 1'b0;
              bus.out_data  <= result;
            end
          end
        end
        REQ1: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT1;
          end
        end
        WAIT1: begin
          if (bus.mem_rsp_valid) begin
            state         <= RESP;
            bus.out_valid <= 1'b1;
            bus.out_err   <= 1'b0;
            bus.out_data  <= result;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit. Three instances cover XLEN=32 with and
// without misaligned support and XLEN=64. The driver pushes the expected result
// of each load; a monitor pops and compares on every result handshake.
module tb_load_align_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance stimulus and observation, widened to 64 bits
  logic        req_valid[3], req_unsigned[3], mem_req_ready[3], mem_rsp_valid[3], out_ready[3];
  logic [1:0]  req_size[3];
  logic [4:0]  req_rd[3];
  logic [63:0] req_addr[3], mem_rsp_data[3];
  logic        req_ready[3], mem_req_valid[3], out_valid[3], out_err[3];
  logic [63:0] mem_req_addr[3], out_data[3];
  logic [4:0]  out_rd[3];

  // Instance 0: XLEN=32 split allowed; 1: XLEN=32 split rejected; 2: XLEN=64
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 2) ? 64 : 32;
    localparam bit AM = (g != 1);
    load_align_unit_if #(.XLEN(W)) ifc ();
    load_align_unit #(.XLEN(W), .ALLOW_MISALIGNED(AM)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
    );
    assign ifc.req_valid     = req_valid[g];
    assign ifc.req_addr      = req_addr[g][W-1:0];
    assign ifc.req_size      = req_size[g];
    assign ifc.req_unsigned  = req_unsigned[g];
    assign ifc.req_rd        = req_rd[g];
    assign ifc.mem_req_ready = mem_req_ready[g];
    assign ifc.mem_rsp_valid = mem_rsp_valid[g];
    assign ifc.mem_rsp_data  = mem_rsp_data[g][W-1:0];
    assign ifc.out_ready     = out_ready[g];
    assign req_ready[g]      = ifc.req_ready;
    assign mem_req_valid[g]  = ifc.mem_req_valid;
    assign mem_req_addr[g]   = 64'(ifc.mem_req_addr);
    assign out_valid[g]      = ifc.out_valid;
    assign out_data[g]       = 64'(ifc.out_data);
    assign out_rd[g]         = ifc.out_rd;
    assign out_err[g]        = ifc.out_err;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  typedef struct {
    int          inst;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: compare every result handshake against the oldest expectation
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k] && out_ready[k]) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out%0d_unexpected: got data 0x%0h with no load outstanding", k, out_data[k]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("out%0d_inst", k), 64'(k), 64'(e.inst));
          check($sformatf("out%0d_data", k), out_data[k], e.data);
          check($sformatf("out%0d_rd", k), 64'(out_rd[k]), 64'(e.rd));
          check($sformatf("out%0d_err", k), 64'(out_err[k]), 64'(e.err));
        end
      end
    end
  end

  // One complete load on instance k acting as memory and consumer.
  // nb = number of memory beats expected (0 = rejected or illegal).
  task automatic run_load(input int k, input string name,
                          input logic [63:0] addr, input logic [1:0] size,
                          input logic uns, input logic [4:0] rd, input int nb,
                          input logic [63:0] a0, input logic [63:0] b0,
                          input logic [63:0] a1, input logic [63:0] b1,
                          input logic [63:0] exp_data, input int stall, input int hold);
    int n;
    int t_acc;
    int lat;
    logic [63:0] a[2];
    logic [63:0] b[2];
    a[0] = a0; a[1] = a1; b[0] = b0; b[1] = b1;
    exp_q.push_back('{inst: k, data: exp_data, rd: rd, err: (nb == 0)});
    out_ready[k] = (hold == 0);

    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_addr[k] = addr; req_size[k] = size;
    req_unsigned[k] = uns; req_rd[k] = rd;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout({name, "_accept"});
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_addr[k]  = 64'h0;
    t_acc = cyc;

    for (int i = 0; i < nb; i++) begin
      n = 0;
      @(negedge clk);
      while (!mem_req_valid[k] && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout($sformatf("%s_memreq%0d", name, i));
      check($sformatf("%s_addr%0d", name, i), mem_req_addr[k], a[i]);
      repeat (stall) begin
        @(negedge clk);
        check($sformatf("%s_hold_valid%0d", name, i), 64'(mem_req_valid[k]), 64'd1);
        check($sformatf("%s_hold_addr%0d", name, i), mem_req_addr[k], a[i]);
      end
      mem_req_ready[k] = 1'b1;
      @(posedge clk); #1;
      mem_req_ready[k] = 1'b0;
      mem_rsp_valid[k] = 1'b1;
      mem_rsp_data[k]  = b[i];
      @(posedge clk); #1;
      mem_rsp_valid[k] = 1'b0;
      mem_rsp_data[k]  = 64'hBAD0_BAD0_BAD0_BAD0;
    end

    n = 0;
    @(negedge clk);
    if (nb == 0) check({name, "_no_memreq"}, 64'(mem_req_valid[k]), 64'd0);
    while (!out_valid[k] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout({name, "_out_valid"});
    lat = (nb == 0) ? 1 : ((nb == 1) ? 3 : 5);
    if (stall == 0) check({name, "_latency"}, 64'(cyc - t_acc + 1), 64'(lat));

    if (hold > 0) begin
      check({name, "_stall_data"}, out_data[k], exp_data);
      check({name, "_stall_req_ready"}, 64'(req_ready[k]), 64'd0);
      repeat (hold - 1) begin
        @(negedge clk);
        check({name, "_stall_valid"}, 64'(out_valid[k]), 64'd1);
        check({name, "_stall_data"}, out_data[k], exp_data);
        check({name, "_stall_req_ready"}, 64'(req_ready[k]), 64'd0);
      end
      @(posedge clk); #1;
      out_ready[k] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_unsigned[k] = 1'b0; req_size[k] = 2'd0; req_rd[k] = 5'd0;
      req_addr[k] = 64'h0; mem_req_ready[k] = 1'b0; mem_rsp_valid[k] = 1'b0;
      mem_rsp_data[k] = 64'h0; out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_req_ready", k), 64'(req_ready[k]), 64'd1);
      check($sformatf("rst%0d_mem_req_valid", k), 64'(mem_req_valid[k]), 64'd0);
      check($sformatf("rst%0d_mem_req_addr", k), mem_req_addr[k], 64'd0);
      check($sformatf("rst%0d_out_valid", k), 64'(out_valid[k]), 64'd0);
      check($sformatf("rst%0d_out_data", k), out_data[k], 64'd0);
      check($sformatf("rst%0d_out_rd", k), 64'(out_rd[k]), 64'd0);
      check($sformatf("rst%0d_out_err", k), 64'(out_err[k]), 64'd0);
    end
    rst_n = 1'b1;

    // XLEN=32, misaligned allowed
    run_load(0, "lb_1003", 64'h1003, 2'd0, 1'b0, 5'd5, 1, 64'h1000, 64'h80AB_CDEF,
             64'h0, 64'h0, 64'hFFFF_FF80, 0, 0);
    run_load(0, "lhu_split", 64'h1003, 2'd1, 1'b1, 5'd6, 2, 64'h1000, 64'h1122_3344,
             64'h1004, 64'h5566_7788, 64'h0000_8811, 0, 0);
    run_load(0, "lh_split", 64'h1003, 2'd1, 1'b0, 5'd7, 2, 64'h1000, 64'h1122_3344,
             64'h1004, 64'h5566_7788, 64'hFFFF_8811, 0, 0);
    run_load(0, "lw_stall", 64'h2000, 2'd2, 1'b0, 5'd8, 1, 64'h2000, 64'h8234_5678,
             64'h0, 64'h0, 64'h8234_5678, 2, 0);
    run_load(0, "ld_on_32", 64'h3000, 2'd3, 1'b0, 5'd9, 0, 64'h0, 64'h0,
             64'h0, 64'h0, 64'h0, 0, 0);
    run_load(0, "lw_wrap", 64'hFFFF_FFFE, 2'd2, 1'b0, 5'd10, 2, 64'hFFFF_FFFC, 64'hAABB_CCDD,
             64'h0, 64'h1122_3344, 64'h3344_AABB, 0, 0);
    run_load(0, "lbu_1001", 64'h1001, 2'd0, 1'b1, 5'd11, 1, 64'h1000, 64'h80AB_CDEF,
             64'h0, 64'h0, 64'h0000_00CD, 0, 0);

    // XLEN=32, misaligned rejected
    run_load(1, "lw_reject", 64'h2002, 2'd2, 1'b0, 5'd12, 0, 64'h0, 64'h0,
             64'h0, 64'h0, 64'h0, 0, 0);
    run_load(1, "lb_noreject", 64'h2003, 2'd0, 1'b0, 5'd13, 1, 64'h2000, 64'h7F00_0000,
             64'h0, 64'h0, 64'h0000_007F, 0, 0);

    // XLEN=64
    run_load(2, "lwu_64", 64'h10, 2'd2, 1'b1, 5'd14, 1, 64'h10, 64'hDEAD_BEEF_8000_0001,
             64'h0, 64'h0, 64'h0000_0000_8000_0001, 3, 0);
    run_load(2, "ld_64_hold", 64'h10, 2'd3, 1'b1, 5'd15, 1, 64'h10, 64'hDEAD_BEEF_8000_0001,
             64'h0, 64'h0, 64'hDEAD_BEEF_8000_0001, 0, 5);
    run_load(2, "lw_64", 64'h10, 2'd2, 1'b0, 5'd16, 1, 64'h10, 64'hDEAD_BEEF_8000_0001,
             64'h0, 64'h0, 64'hFFFF_FFFF_8000_0001, 0, 0);
    run_load(2, "ld_64_split", 64'h14, 2'd3, 1'b0, 5'd17, 2, 64'h10, 64'h0706_0504_0302_0100,
             64'h18, 64'h0F0E_0D0C_0B0A_0908, 64'h0B0A_0908_0706_0504, 0, 0);

    // Reset while waiting for the first beat, then a stray response
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 64'h1003; req_size[0] = 2'd0;
    req_unsigned[0] = 1'b0; req_rd[0] = 5'd20;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    mem_req_ready[0] = 1'b1;
    @(posedge clk); #1;
    mem_req_ready[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_ready", 64'(req_ready[0]), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_mid_mem_req_valid", 64'(mem_req_valid[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid[0] = 1'b1;
    mem_rsp_data[0]  = 64'h80AB_CDEF;
    @(posedge clk); #1;
    mem_rsp_valid[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_late_out_valid", 64'(out_valid[0]), 64'd0);
      check("rst_late_req_ready", 64'(req_ready[0]), 64'd1);
      check("rst_late_mem_req_valid", 64'(mem_req_valid[0]), 64'd0);
    end
    run_load(0, "lb_after_rst", 64'h1002, 2'd0, 1'b0, 5'd21, 1, 64'h1000, 64'h80AB_CDEF,
             64'h0, 64'h0, 64'hFFFF_FFAB, 0, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised load-data alignment and extension unit sitting between the execute stage's load request and the data-memory port. It generalises the immediate/extension datapath to XLEN of 32 or 64. It adds doubleword and unsigned-word loads, and splits misaligned loads into two aligned memory beats that are merged before extension. All interfaces use valid/ready handshakes, and at most one load is in flight.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- ALLOW_MISALIGNED, 1: 1 = split misaligned loads into two beats; 0 = flag them as errors.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  XLEN  byte address.
- req_size  in  2  0=byte, 1=half, 2=word, 3=double.
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- req_rd  in  5  destination register tag; passed through unchanged.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  aligned address; low log2(XLEN/8) bits are 0.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  aligned read data, little-endian.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  XLEN  aligned, extended load result.
- out_rd  out  5  tag of the request that produced the result.
- out_err  out  1  result is an illegal or misaligned-rejected load; out_data = 0.

## Operation
- B = XLEN/8. off = req_addr mod B. nbytes = 1 << req_size.
- A request is illegal when req_size = 3 and XLEN = 32.
- A request is split when off + nbytes > B.
- Handshake on req_valid & req_ready. On acceptance the unit latches addr, size, unsigned and rd.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE -> REQ0 on acceptance of a legal request that is not rejected.
  - IDLE -> RESP with out_err = 1 on acceptance of an illegal request, or a split request when ALLOW_MISALIGNED = 0. No memory access is made.
  - REQ0: mem_req_valid = 1, mem_req_addr = addr with the low bits cleared. On mem_req_ready go to WAIT0.
  - WAIT0: on mem_rsp_valid capture beat0. Go to REQ1 if split, else to RESP.
  - REQ1: mem_req_addr = aligned addr + B, wrapping modulo 2^XLEN. On mem_req_ready go to WAIT1.
  - WAIT1: on mem_rsp_valid capture beat1 and go to RESP.
  - RESP: out_valid = 1. On out_ready go to IDLE.
- Merge rule: w = {beat1, beat0} (beat1 = 0 if not split), shifted right by 8*off. The low nbytes bytes are kept.
- Extension rule: sign- or zero-extend the kept bytes to XLEN. req_unsigned is ignored when nbytes = B.
- mem_rsp_valid is ignored in every state except WAIT0 and WAIT1.
- Outputs are registered; out_data, out_rd and out_err are stable for as long as out_valid = 1.

## Timing
- Reset values:
  - State is IDLE and req_ready = 1.
  - mem_req_valid = 0 and mem_req_addr = 0.
  - out_valid = 0, out_data = 0, out_rd = 0, out_err = 0.
- Reset is asynchronous, including mid-transaction. The in-flight load is discarded, and a late mem_rsp_valid arriving after reset is ignored because the unit is in IDLE.
- Accept in cycle t: mem_req_valid rises in t+1.
- The memory response is accepted no earlier than the cycle after the mem_req handshake.
- out_valid rises in the cycle after the final response beat is captured.
- Minimum latency from acceptance to out_valid: 3 cycles aligned, 5 cycles split.
- Rejected or illegal requests: out_valid rises at t+1 with no mem_req_valid.
- Backpressure: mem_req_valid is held with a constant address until mem_req_ready. out_valid is held until out_ready.
- A new request can be accepted in the cycle after the RESP handshake, giving back-to-back throughput of one load per 4 cycles aligned.

## Test plan
- Sign-extended byte, XLEN=32: lb at 0x1003, mem word 0x80AB_CDEF -> one mem_req at 0x1000; out_data = 0xFFFF_FF80.
- Split halfword, XLEN=32: lhu at 0x1003, beats 0x1122_3344 then 0x5566_7788 -> mem_req at 0x1000 then 0x1004; out_data = 0x0000_8811.
- Same split as signed: lh with the same beats -> out_data = 0xFFFF_8811.
- Rejections:
  - ALLOW_MISALIGNED=0, lw at 0x2002 -> no mem_req_valid; out_err = 1, out_data = 0, out_valid at t+1.
  - XLEN=32, size 3 -> out_err = 1.
- XLEN=64 with backpressure:
  - lwu at 0x10, beat 0xDEAD_BEEF_8000_0001 -> 0x0000_0000_8000_0001.
  - ld at 0x10, same beat -> 0xDEAD_BEEF_8000_0001.
  - Hold out_ready = 0 for 5 cycles -> out_valid and out_data stay stable and req_ready stays 0.
- Reset in WAIT0, then inject mem_rsp_valid -> the unit stays in IDLE with out_valid = 0, and the next lb completes correctly.
